// File: rtl/apb_slave_regfile.sv
// APB4 completer with a small word-addressed register file.
// Register 0 is a constant ID word; registers 1..NUM_REGS-1 are read/write
// with byte-lane strobes. Each access phase is stretched by WAIT_CYCLES
// wait states before PREADY is returned for exactly one cycle.
module apb_slave_regfile #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    STRB_WIDTH  = DATA_WIDTH / 8,
  parameter int                    NUM_REGS    = 16,
  parameter int                    WAIT_CYCLES = 1,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE    = 32'hA0B4_0001
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [STRB_WIDTH-1:0] PSTRB,
  input  logic [2:0]            PPROT,
  output logic                  PREADY,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  PSLVERR
);

  localparam int         IDX_W    = ADDR_WIDTH - 2;
  localparam int         SEL_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_READY
  } state_e;

  state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  // Register storage; index 0 is the ID constant and has no flops.
  logic [DATA_WIDTH-1:0] regs_q [1:NUM_REGS-1];
  logic [DATA_WIDTH-1:0] rd_words [0:NUM_REGS-1];
  logic [DATA_WIDTH-1:0] wmask;

  logic [IDX_W-1:0] idx;
  logic [SEL_W-1:0] sel;
  logic             in_range;
  logic             err;
  logic             commit;

  // Protection bits and byte offset carry no meaning for this block.
  logic unused_bits;
  assign unused_bits = ^{PPROT, PADDR[1:0]};

  // Full-width compare so upper address bits can never alias onto low words.
  assign idx      = PADDR[ADDR_WIDTH-1:2];
  assign sel      = idx[SEL_W-1:0];
  assign in_range = (idx < IDX_W'(NUM_REGS));
  assign err      = !in_range || (PWRITE && (idx == '0));
  assign commit   = (state_q == S_READY) && PWRITE && !err;

  // Expand the byte strobes into a bit mask, one lane at a time.
  for (genvar gi = 0; gi < STRB_WIDTH; gi++) begin : g_lane
    assign wmask[8*gi +: 8] = {8{PSTRB[gi]}};
  end

  // Flatten ID + storage into one readable array for the output mux.
  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_rd
    if (gi == 0) begin : g_id
      assign rd_words[gi] = ID_VALUE;
    end else begin : g_reg
      assign rd_words[gi] = regs_q[gi];
    end
  end

  // State register and wait counter.
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: setup in IDLE, count down in WAIT, one-cycle READY.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        // PENABLE high while idle is a protocol violation and is ignored.
        if (PSEL && !PENABLE) begin
          if (WAIT_CYCLES == 0) begin
            state_d = S_READY;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      S_WAIT: begin
        if (!PSEL) begin
          state_d = S_IDLE;
        end else if (cnt_q == 4'd0) begin
          state_d = S_READY;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_READY: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Byte-strobed write commit on the edge that closes READY.
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      for (int r = 1; r < NUM_REGS; r++) begin
        regs_q[r] <= '0;
      end
    end else if (commit) begin
      for (int r = 1; r < NUM_REGS; r++) begin
        if (sel == SEL_W'(r)) begin
          regs_q[r] <= (regs_q[r] & ~wmask) | (PWDATA & wmask);
        end
      end
    end
  end

  // Response outputs are decoded from state and the live address.
  always_comb begin
    PREADY  = (state_q == S_READY);
    PSLVERR = (state_q == S_READY) && err;
    PRDATA  = '0;
    if ((state_q == S_READY) && !PWRITE && !err) begin
      PRDATA = rd_words[sel];
    end
  end

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Scoreboard bench for apb_slave_regfile. Two instances share one APB bus:
// instance 0 has three wait states, instance 1 has none. The driver pushes
// the expected response of each transfer; a monitor pops per instance.
module tb_apb_slave_regfile;

  localparam int          NREG = 16;
  localparam logic [31:0] ID   = 32'hA0B4_0001;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic [1:0]  mask;   // which instances are expected to respond
    int          id;
  } exp_t;

  logic        clk = 1'b0;
  logic        presetn;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic [3:0]  pstrb;
  logic [2:0]  pprot;
  logic        pready  [2];
  logic [31:0] prdata  [2];
  logic        pslverr [2];

  exp_t        exp_q[$];
  logic [31:0] model [NREG];
  int          checks = 0;
  int          errors = 0;
  int          rd_ptr [2];
  int          lat    [2];
  logic        prev_rdy [2];
  logic        idle_chk = 1'b0;
  logic        end_chk  = 1'b0;
  logic        done     = 1'b0;
  int          xfer_id  = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    apb_slave_regfile #(
      .NUM_REGS   (NREG),
      .WAIT_CYCLES((gi == 0) ? 3 : 0),
      .ID_VALUE   (ID)
    ) u_dut (
      .PCLK   (clk),
      .PRESETn(presetn),
      .PSEL   (psel),
      .PENABLE(penable),
      .PWRITE (pwrite),
      .PADDR  (paddr),
      .PWDATA (pwdata),
      .PSTRB  (pstrb),
      .PPROT  (pprot),
      .PREADY (pready[gi]),
      .PRDATA (prdata[gi]),
      .PSLVERR(pslverr[gi])
    );
  end

  // Monitor: samples on the falling edge, checks every PREADY against the queue.
  always @(negedge clk) begin
    if (!presetn) begin
      for (int k = 0; k < 2; k++) prev_rdy[k] = 1'b0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (psel && !penable) lat[k] = 0;
        else                  lat[k] = lat[k] + 1;
        if (prev_rdy[k]) begin
          checks++;
          if (pready[k]) begin
            errors++;
            $display("FAIL ready_width inst%0d: PREADY=%b, required 0 after one cycle", k, pready[k]);
          end
        end
        if (pready[k]) begin
          while (rd_ptr[k] < exp_q.size() && !exp_q[rd_ptr[k]].mask[k]) rd_ptr[k]++;
          checks++;
          if (rd_ptr[k] >= exp_q.size()) begin
            errors++;
            $display("FAIL unexpected_ready inst%0d: PREADY=1, required no response", k);
          end else begin
            if (pslverr[k] !== exp_q[rd_ptr[k]].err || prdata[k] !== exp_q[rd_ptr[k]].rdata ||
                lat[k] != ((k == 0) ? 4 : 1)) begin
              errors++;
              $display("FAIL xfer%0d inst%0d: PRDATA=%h PSLVERR=%b latency=%0d, required PRDATA=%h PSLVERR=%b latency=%0d",
                       exp_q[rd_ptr[k]].id, k, prdata[k], pslverr[k], lat[k],
                       exp_q[rd_ptr[k]].rdata, exp_q[rd_ptr[k]].err, (k == 0) ? 4 : 1);
            end
            $display("xfer%0d inst%0d: PRDATA=%h PSLVERR=%b latency=%0d",
                     exp_q[rd_ptr[k]].id, k, prdata[k], pslverr[k], lat[k]);
            rd_ptr[k]++;
          end
        end
        prev_rdy[k] = pready[k];
        if (idle_chk) begin
          checks++;
          if (pready[k] !== 1'b0 || pslverr[k] !== 1'b0 || prdata[k] !== 32'h0) begin
            errors++;
            $display("FAIL idle_outputs inst%0d: PREADY=%b PSLVERR=%b PRDATA=%h, required 0 0 0",
                     k, pready[k], pslverr[k], prdata[k]);
          end
        end
        if (end_chk) begin
          checks++;
          if (rd_ptr[k] != exp_q.size()) begin
            errors++;
            $display("FAIL drain inst%0d: responses=%0d, required %0d", k, rd_ptr[k], exp_q.size());
          end
        end
      end
      if (end_chk) done = 1'b1;
    end
  end

  // Reference model: word-indexed array, byte-lane merge, error rules.
  task automatic predict(input logic w, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] strb, input logic [1:0] mask);
    exp_t        e;
    int unsigned widx;
    widx    = addr >> 2;
    e.err   = (widx >= NREG) || (w && widx == 0);
    e.rdata = 32'h0;
    e.mask  = mask;
    e.id    = xfer_id++;
    if (!e.err) begin
      if (w) begin
        for (int b = 0; b < 4; b++)
          if (strb[b]) model[widx][8*b +: 8] = wdata[8*b +: 8];
      end else begin
        e.rdata = (widx == 0) ? ID : model[widx];
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic clear_model();
    for (int r = 0; r < NREG; r++) model[r] = 32'h0;
  endtask

  // Full APB transfer; returns one cycle after the slow instance's READY.
  task automatic xfer(input logic w, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] strb);
    int n;
    predict(w, addr, wdata, strb, 2'b11);
    psel = 1'b1; penable = 1'b0; pwrite = w; paddr = addr; pwdata = wdata; pstrb = strb;
    pprot = 3'($urandom);
    @(posedge clk); #1;
    penable = 1'b1;
    n = 0;
    while (!pready[0]) begin
      @(posedge clk); #1;
      n++;
      if (n > 50) begin
        $display("FAIL timeout xfer%0d: PREADY=0, required 1 within 50 cycles", xfer_id - 1);
        $fatal(1, "timeout");
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int cycles);
    psel = 1'b0; penable = 1'b0; paddr = $urandom;
    repeat (cycles) begin @(posedge clk); #1; end
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin rd_ptr[k] = 0; lat[k] = 0; prev_rdy[k] = 1'b0; end
    clear_model();
    presetn = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = 32'h0; pwdata = 32'h0; pstrb = 4'h0; pprot = 3'h0;
    repeat (3) @(posedge clk);
    #1 presetn = 1'b1;
    @(posedge clk); #1;
    idle_chk = 1'b1; @(posedge clk); #1; idle_chk = 1'b0;

    // Reset contents, word write, read-back.
    xfer(1'b0, 32'h0000_000C, 32'h0, 4'hF);
    xfer(1'b1, 32'h0000_000C, 32'hDEAD_BEEF, 4'hF);
    idle(1);
    xfer(1'b0, 32'h0000_000C, 32'h0, 4'hF);
    // Byte strobes and the empty-strobe write.
    xfer(1'b1, 32'h0000_0014, 32'h1122_3344, 4'hF);
    xfer(1'b1, 32'h0000_0014, 32'hAABB_CCDD, 4'b0101);
    xfer(1'b0, 32'h0000_0014, 32'h0, 4'h0);
    xfer(1'b1, 32'h0000_0014, 32'h5555_5555, 4'h0);
    xfer(1'b0, 32'h0000_0014, 32'h0, 4'h0);
    // Error responses.
    xfer(1'b1, 32'h0000_0000, 32'h1234_5678, 4'hF);
    xfer(1'b0, 32'h0000_0000, 32'h0, 4'h0);
    xfer(1'b0, 32'h0000_0040, 32'h0, 4'h0);
    xfer(1'b1, 32'h0000_0004, 32'h0BAD_F00D, 4'hF);
    xfer(1'b1, 32'h1000_0004, 32'hFFFF_FFFF, 4'hF);
    xfer(1'b0, 32'h0000_0004, 32'h0, 4'h0);
    // Back-to-back write then read, plus a misaligned read.
    xfer(1'b1, 32'h0000_0008, 32'hCAFE_0123, 4'hF);
    xfer(1'b0, 32'h0000_0008, 32'h0, 4'h0);
    xfer(1'b0, 32'h0000_000F, 32'h0, 4'h0);
    idle(2);

    // Reset while the slow instance waits; the fast one has already responded.
    predict(1'b1, 32'h0000_0010, 32'h7777_8888, 4'hF, 2'b10);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h10; pwdata = 32'h7777_8888; pstrb = 4'hF;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    presetn = 1'b0;
    @(posedge clk); #1;
    presetn = 1'b1; psel = 1'b0; penable = 1'b0;
    clear_model();
    idle_chk = 1'b1; @(posedge clk); #1; idle_chk = 1'b0;
    xfer(1'b0, 32'h0000_0010, 32'h0, 4'h0);
    xfer(1'b0, 32'h0000_000C, 32'h0, 4'h0);

    // Randomized traffic.
    for (int t = 0; t < 200; t++) begin
      logic [31:0] a;
      if ($urandom_range(0, 4) == 0) a = $urandom;
      else a = {$urandom_range(0, 19), 2'($urandom)};
      xfer(1'($urandom), a, $urandom, 4'($urandom));
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    end
    idle(2);

    end_chk = 1'b1;
    while (!done) @(posedge clk);
    #1 end_chk = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
